// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// mips_multicycle_ctrl : Moore control FSM for the multi-cycle MIPS core
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
  parameter int USE_MEM_READY = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q,   state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ready;
  logic             retire;
  logic             ir_write_raw, pc_en_raw, reg_write_raw, mem_write_raw;

  assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    mem_read      = 1'b0;
    mem_write_raw = 1'b0;
    iord          = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    pc_en_raw     = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = ready;
        pc_en_raw    = ready;
        state_d      = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        retire        = ready;
        state_d       = ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en_raw = zero;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural writes are suppressed while reset is held so an abandoned
  // instruction leaves no trace in the PC, IR, register file or memory.
  assign ir_write  = ir_write_raw  & ~reset;
  assign pc_en     = pc_en_raw     & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign mem_write = mem_write_raw & ~reset;

  assign retired_d = retire ? (retired_q + CNT_ONE) : retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// tb_mips_multicycle_ctrl : directed self-checking bench for the control FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset, reset0;
  logic [5:0] opcode;
  logic zero, mem_ready;

  logic mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, illegal_op, pc_en;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [31:0] retired;

  logic mem_read0, mem_write0, iord0, ir_write0, reg_dst0, mem_to_reg0, reg_write0;
  logic alu_src_a0, illegal_op0, pc_en0;
  logic [1:0] alu_src_b0, alu_op0, pc_src0;
  logic [3:0] state0;
  logic [2:0] retired0;

  int n_tests = 0;
  int n_fail  = 0;
  int irw_cnt, memwr_cnt, ill_cnt;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.USE_MEM_READY(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  // Ready ignored and tied low; small counter so wrap is reachable.
  mips_multicycle_ctrl #(.USE_MEM_READY(0), .CNT_W(3)) dut0 (
    .clk(clk), .reset(reset0), .opcode(opcode), .zero(zero), .mem_ready(1'b0),
    .mem_read(mem_read0), .mem_write(mem_write0), .iord(iord0), .ir_write(ir_write0),
    .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0), .pc_src(pc_src0),
    .pc_en(pc_en0), .illegal_op(illegal_op0), .state(state0), .retired(retired0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tr: expected state per cycle, first cycle in the top nibble.
  // rdy: mem_ready per cycle, first cycle in the top bit.
  task automatic run(input string tag, input logic [5:0] op, input logic z,
                     input logic [39:0] tr, input logic [9:0] rdy, input int n,
                     input bit with0);
    logic [3:0] es;
    irw_cnt = 0; memwr_cnt = 0; ill_cnt = 0;
    opcode = op;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      es = tr[39-4*i -: 4];
      mem_ready = rdy[9-i];
      #1;
      chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
      if (with0) chk({tag, ".state0"}, {28'd0, state0}, {28'd0, es});
      chk({tag, ".alu_op"}, {30'd0, alu_op},
          (es == 4'd6) ? 32'd2 : (es == 4'd8) ? 32'd1 : 32'd0);
      if (es == 4'd0 || es == 4'd3) chk({tag, ".mem_read"}, {31'd0, mem_read}, 32'd1);
      if (es == 4'd8) begin
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, z});
        chk({tag, ".pc_src"}, {30'd0, pc_src}, 32'd1);
      end
      if (ir_write) irw_cnt++;
      if (mem_write && iord) memwr_cnt++;
      if (illegal_op) ill_cnt++;
      tick();
    end
    mem_ready = 1'b1;
    chk({tag, ".end_state"}, {28'd0, state}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; reset0 = 1'b1;
    opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst.state", {28'd0, state}, 32'd0);
    chk("rst.retired", retired, 32'd0);
    chk("rst.ir_write_forced", {31'd0, ir_write}, 32'd0);
    chk("rst.pc_en_forced", {31'd0, pc_en}, 32'd0);
    reset = 1'b0; reset0 = 1'b0;
    #1;
    chk("rel.ir_write", {31'd0, ir_write}, 32'd1);
    chk("rel.pc_en", {31'd0, pc_en}, 32'd1);
    chk("rel.ir_write0", {31'd0, ir_write0}, 32'd1);

    // Main sequence: 4+5+4+3+4+3 = 23 cycles, both instances in lockstep.
    run("R",    6'b000000, 1'b0, 40'h0167000000, 10'h3FF, 4, 1'b1);
    run("LW",   6'b100011, 1'b0, 40'h0123400000, 10'h3FF, 5, 1'b1);
    run("SW",   6'b101011, 1'b0, 40'h0125000000, 10'h3FF, 4, 1'b1);
    run("BEQ1", 6'b000100, 1'b1, 40'h0180000000, 10'h3FF, 3, 1'b1);
    run("ADDI", 6'b001000, 1'b0, 40'h019A000000, 10'h3FF, 4, 1'b1);
    run("J",    6'b000010, 1'b0, 40'h01B0000000, 10'h3FF, 3, 1'b1);
    exp_ret = 32'd6;
    chk("seq.retired", retired, exp_ret);
    chk("seq.retired0", {29'd0, retired0}, 32'd6);
    run("J2", 6'b000010, 1'b0, 40'h01B0000000, 10'h3FF, 3, 1'b1);
    run("J3", 6'b000010, 1'b0, 40'h01B0000000, 10'h3FF, 3, 1'b1);
    exp_ret = 32'd8;
    chk("wrap.retired", retired, exp_ret);
    chk("wrap.retired0", {29'd0, retired0}, 32'd0);
    reset0 = 1'b1;

    run("BEQ0", 6'b000100, 1'b0, 40'h0180000000, 10'h3FF, 3, 1'b0);
    exp_ret++;
    chk("beq0.retired", retired, exp_ret);

    // LW: 3 stall cycles in FETCH, 2 in MEMRD, 10 cycles total.
    run("LWst", 6'b100011, 1'b0, 40'h0000123334, 10'b0001110011, 10, 1'b0);
    exp_ret++;
    chk("lwst.ir_write_pulses", irw_cnt, 32'd1);
    chk("lwst.retired", retired, exp_ret);

    run("SWst", 6'b101011, 1'b0, 40'h0125550000, 10'b1110011111, 6, 1'b0);
    exp_ret++;
    chk("swst.write_cycles", memwr_cnt, 32'd3);
    chk("swst.retired", retired, exp_ret);

    run("ILL", 6'b111111, 1'b0, 40'h0100000000, 10'h3FF, 2, 1'b0);
    chk("ill.pulses", ill_cnt, 32'd1);
    chk("ill.retired", retired, exp_ret);

    // Reset held two cycles while in EXEC.
    opcode = 6'b000000; mem_ready = 1'b1;
    tick(); tick();
    chk("mid.in_exec", {28'd0, state}, 32'd6);
    reset = 1'b1;
    #1;
    chk("mid.reg_write_exec", {31'd0, reg_write}, 32'd0);
    tick();
    chk("mid.state", {28'd0, state}, 32'd0);
    chk("mid.retired", retired, 32'd0);
    chk("mid.reg_write", {31'd0, reg_write}, 32'd0);
    chk("mid.ir_write_forced", {31'd0, ir_write}, 32'd0);
    tick();
    chk("mid.reg_write2", {31'd0, reg_write}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid.rel_state", {28'd0, state}, 32'd0);
    chk("mid.rel_ir_write", {31'd0, ir_write}, 32'd1);
    chk("mid.rel_pc_en", {31'd0, pc_en}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM sequencing the shared ALU, register file, instruction register and unified memory of the multi-cycle MIPS core.
- Decodes opcode and steps each instruction through fetch, decode, execute, memory and writeback, driving alu_op into ALU_control and the ALU operand muxes.
- Stalls on memory through a ready handshake and counts retired instructions.

Parameters:
- USE_MEM_READY, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready treated as constant 1.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instr[31:26] from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut.
- ir_write  out  1  load instruction register.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op  out  2  to ALU_control: 00 add, 01 sub, 10 funct.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- state  out  4  current state (debug).
- retired  out  CNT_W  retired instruction count.

Behaviour:
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- State register is updated on the rising clk edge. All outputs decode combinationally from state, mem_ready and zero. Every output not listed for a state is 0.
- Reset:
  - A clk edge with reset=1 sets state = FETCH (0) and retired = 0.
  - While reset=1, ir_write, pc_en, reg_write and mem_write are forced 0.
  - Reset mid-instruction abandons it with no write; that instruction is not counted.
- States and their outputs:
  - FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_en=mem_ready. Stays in FETCH while !mem_ready, else goes to DECODE.
  - DECODE (1): alu_src_b=11, alu_op=00 (branch target precompute). Next state:
    - LW/SW -> MEMADR
    - R -> EXEC
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other opcode -> FETCH with illegal_op=1 this cycle; not counted.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if LW, MEMWR if SW.
  - MEMRD (3): mem_read=1, iord=1. Stays while !mem_ready, else goes to MEMWB.
  - MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
  - MEMWR (5): iord=1, mem_write=1, held stable until mem_ready. Goes to FETCH on mem_ready.
  - EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
  - ALUWB (7): reg_dst=1, reg_write=1. Goes to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Goes to FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
  - ADDIWB (10): reg_dst=0, reg_write=1. Goes to FETCH.
  - JUMP (11): pc_src=10, pc_en=1. Goes to FETCH.
  - Codes 12-15: go to FETCH, no outputs asserted.
- retired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - Wraps modulo 2^CNT_W.
- Latency with mem_ready=1 (cycles, FETCH to next FETCH): R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3. Each cycle with mem_ready=0 in a wait state adds one.
- opcode is sampled only in DECODE and MEMADR; the IR is stable there since ir_write=0.

Test Plan:
- Reset held 2 cycles mid-EXEC -> state=0, retired=0, reg_write never asserted; first FETCH after release shows ir_write=pc_en=1 (mem_ready=1).
- Opcode sequence R, LW, SW, BEQ, ADDI, J with mem_ready=1:
  - State traces 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9,10 / 0,1,11.
  - retired=6 after 23 cycles.
  - alu_op is 10 only in EXEC and 01 only in BRANCH.
- BEQ with zero=1 -> pc_en=1 with pc_src=01 in BRANCH. With zero=0 -> pc_en=0. Both increment retired.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEMRD:
  - ir_write pulses once, on the ready cycle.
  - Instruction completes in 10 cycles.
  - mem_read held high throughout both waits.
- SW with mem_ready low 2 cycles in MEMWR -> mem_write=1 and iord=1 stable for 3 cycles; exactly one retired increment.
- opcode=111111 -> DECODE asserts illegal_op for exactly 1 cycle, returns to FETCH, retired unchanged.
- USE_MEM_READY=0 with mem_ready tied 0 -> latencies identical to the mem_ready=1 case.
